// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave (ID, then timestamp)
// and reports whether the running hardware image matches the expected build.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1519144068,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        match;

    assign match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // IDLE is only reachable from reset, so AUTO_START acts as a one-shot
                    if (start || (state == IDLE && AUTO_START)) begin
                        state       <= RD_ID;
                        wait_cnt    <= '0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        mismatch    <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!avm_waitrequest) begin
                        wait_cnt <= '0;
                        if (state == RD_ID) begin
                            id_value    <= avm_readdata;
                            avm_address <= 1'b1;
                            state       <= RD_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            avm_read <= 1'b0;
                            state    <= CHECK;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        id_ok    <= 1'b0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                CHECK: begin
                    id_ok    <= match;
                    mismatch <= !match;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: randomized stall/data scenarios against a transaction-level
// model of the expected result, latency and read-strobe timing.
module tb_sysid_checker;
    localparam int          T   = 4;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1519144068;

    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_address, avm_read, busy, done, id_ok, mismatch, timeout;
    logic [31:0] id_value, ts_value;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_id = '0, exp_ts = '0;

    sysid_checker #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .id_ok(id_ok), .mismatch(mismatch),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ok"}, 32'(id_ok), 32'd0);
        chk({tag, "_mis"}, 32'(mismatch), 32'd0);
        chk({tag, "_to"}, 32'(timeout), 32'd0);
        chk({tag, "_id"}, id_value, 32'd0);
        chk({tag, "_ts"}, ts_value, 32'd0);
    endtask

    // s0/s1: stall cycles the slave inserts per word (>= T means stuck)
    task automatic run_check(input int s0, input int s1, input logic [31:0] d0,
                             input logic [31:0] d1, input bit use_start, input int abort_at);
        int          rc, lat, st0, st1;
        bit          to, ok;
        logic [31:0] nid, nts;
        nid = exp_id; nts = exp_ts; to = 0; ok = 0; st0 = 0; st1 = 0;
        if (s0 >= T) begin
            rc = T; to = 1;
        end else begin
            nid = d0;
            if (s1 >= T) begin
                rc = s0 + 1 + T; to = 1;
            end else begin
                rc = s0 + s1 + 2; nts = d1; ok = (d0 == EID) && (d1 == ETS);
            end
        end
        lat = to ? rc : rc + 1;
        if (use_start) start = 1'b1; else reset_n = 1'b1;
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
        for (int j = 0; j <= lat + 2; j++) begin
            @(negedge clock);
            start = (j < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("read", 32'(avm_read), 32'(j < rc));
            if (j < rc) chk("addr", 32'(avm_address), 32'(j > s0));
            chk("busy", 32'(busy), 32'(j < lat));
            chk("done", 32'(done), 32'(j >= lat));
            chk("id_ok", 32'(id_ok), 32'(j >= lat && ok));
            chk("mismatch", 32'(mismatch), 32'(j >= lat && !to && !ok));
            chk("timeout", 32'(timeout), 32'(j >= lat && to));
            if (j >= lat) begin
                chk("id_value", id_value, nid);
                chk("ts_value", ts_value, nts);
            end
            if (j == abort_at) begin
                reset_n = 1'b0;
                start = 1'b0;
                #1;
                chk_zero("abort");
                exp_id = '0;
                exp_ts = '0;
                @(negedge clock);
                return;
            end
            if (avm_read && !avm_address) begin
                avm_waitrequest = st0 < s0;
                avm_readdata = (st0 < s0) ? $urandom : d0;
                if (st0 < s0) st0++;
            end else if (avm_read) begin
                avm_waitrequest = st1 < s1;
                avm_readdata = (st1 < s1) ? $urandom : d1;
                if (st1 < s1) st1++;
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata = $urandom;
            end
        end
        exp_id = nid;
        exp_ts = nts;
    endtask

    initial begin
        bit          need_auto;
        int          ab;
        logic [31:0] d0, d1;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        run_check(0, 0, EID, ETS, 0, -1);
        run_check(0, 0, EID, ETS + 32'd1, 1, -1);
        run_check(3, 3, EID, ETS, 1, -1);
        run_check(0, 20, EID, ETS, 1, -1);
        run_check(20, 0, EID, ETS, 1, -1);
        run_check(0, 0, EID, ETS, 1, -1);
        run_check(20, 0, EID, ETS, 1, 2);
        run_check(0, 0, EID, ETS, 0, -1);
        need_auto = 0;
        for (int i = 0; i < 40; i++) begin
            d0 = ($urandom_range(0, 3) == 0) ? $urandom : EID;
            d1 = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_check(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), d0, d1, !need_auto, ab);
            need_auto = (ab >= 0);
        end
        if (need_auto) run_check(0, 0, EID, ETS, 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
